// File: rtl/snes_mem_pkg.sv
// snes_mem_pkg: shared states, wait-counter width and cycle-length limits
// for the SNES cartridge memory sequencer.
package snes_mem_pkg;

  localparam int WAIT_W = 4;
  localparam int RD_MIN = 2;
  localparam int RD_MAX = 15;
  localparam int WR_MIN = 2;
  localparam int WR_MAX = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNES_RD,
    S_SNES_WR,
    S_MCU_RD,
    S_MCU_WR
  } state_e;

  typedef enum logic {
    K_RD,
    K_WR
  } kind_e;

  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  data;
  } req_t;

  function automatic logic [WAIT_W-1:0] clamp_len(
    input int n,
    input int lo,
    input int hi
  );
    if (n < lo) return WAIT_W'(lo);
    if (n > hi) return WAIT_W'(hi);
    return WAIT_W'(n);
  endfunction

endpackage

// File: rtl/snes_mem_sequencer_if.sv
// snes_mem_sequencer_if: SNES, MCU and memory-side bus bundle.
// master = request/memory model side, slave = sequencer.
interface snes_mem_sequencer_if;

  logic        snes_rd_start;
  logic        snes_wr_end;
  logic [23:0] rom_addr;
  logic        rom_hit;
  logic        is_writable;
  logic [7:0]  snes_data_in;
  logic [7:0]  snes_data_out;

  logic        mcu_rrq;
  logic        mcu_wrq;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_dout;
  logic [7:0]  mcu_din;
  logic        mcu_rdy;

  logic [23:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        mem_drive;

  logic [15:0] stat_snes_rd;
  logic [15:0] stat_mcu_defer;

  modport master (
    output snes_rd_start, snes_wr_end, rom_addr, rom_hit,
    output is_writable, snes_data_in,
    output mcu_rrq, mcu_wrq, mcu_addr, mcu_dout,
    output mem_din,
    input  snes_data_out, mcu_din, mcu_rdy,
    input  mem_addr, mem_dout, mem_oe_n, mem_we_n, mem_drive,
    input  stat_snes_rd, stat_mcu_defer
  );

  modport slave (
    input  snes_rd_start, snes_wr_end, rom_addr, rom_hit,
    input  is_writable, snes_data_in,
    input  mcu_rrq, mcu_wrq, mcu_addr, mcu_dout,
    input  mem_din,
    output snes_data_out, mcu_din, mcu_rdy,
    output mem_addr, mem_dout, mem_oe_n, mem_we_n, mem_drive,
    output stat_snes_rd, stat_mcu_defer
  );

endinterface

// File: rtl/snes_mem_sequencer_mem_strobe_timer.sv
// mem_strobe_timer: shared OE_N/WE_N/DRIVE generator; holds the strobe
// for 'length' cycles after load and flags the final cycle.
module mem_strobe_timer
  import snes_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] length,
  input  kind_e             kind,
  output logic              oe_n,
  output logic              we_n,
  output logic              drive,
  output logic              last
);

  logic              active;
  logic [WAIT_W-1:0] cnt;
  kind_e             kind_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      kind_q <= K_RD;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= length;
      kind_q <= kind;
    end else if (active) begin
      if (cnt == WAIT_W'(1)) active <= 1'b0;
      cnt <= cnt - 1'b1;
    end
  end

  // Strobes come straight off flops so reset releases them asynchronously
  assign oe_n  = !(active && kind_q == K_RD);
  assign we_n  = !(active && kind_q == K_WR);
  assign drive = active && kind_q == K_WR;
  assign last  = active && cnt == WAIT_W'(1);

endmodule

// File: rtl/snes_mem_sequencer.sv
// snes_mem_sequencer: runs decoded SNES cycles and MCU requests on the
// cartridge RAM. Optional counters enabled by `define ACCESS_STATS_EN.
module snes_mem_sequencer
  import snes_mem_pkg::*;
#(
  parameter int RD_CYCLES = 5,
  parameter int WR_CYCLES = 4,
  parameter int MCU_GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  snes_mem_sequencer_if.slave  bus
);

  localparam logic [WAIT_W-1:0] RD_LEN =
    clamp_len(RD_CYCLES, RD_MIN, RD_MAX);
  localparam logic [WAIT_W-1:0] WR_LEN =
    clamp_len(WR_CYCLES, WR_MIN, WR_MAX);
  localparam logic [WAIT_W-1:0] GUARD = WAIT_W'(MCU_GUARD);

  state_e            state, state_n;
  logic              snes_rd_pend, snes_wr_pend;
  logic              mcu_pend, mcu_wr;
  logic [23:0]       srd_addr;
  req_t              swr, mreq;
  logic [WAIT_W-1:0] guard;
  logic              load, last, done;
  logic [WAIT_W-1:0] len;
  kind_e             kind;
  logic              snes_op, mcu_op;
  logic [23:0]       mem_addr;
  logic [7:0]        mem_dout, snes_data_out, mcu_din;

  assign snes_op = state inside {S_SNES_RD, S_SNES_WR};
  assign mcu_op  = state inside {S_MCU_RD, S_MCU_WR};
  assign done    = (snes_op || mcu_op) && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // SNES always wins in IDLE; MCU waits out the post-SNES guard
  always_comb begin
    state_n = state;
    load    = 1'b0;
    len     = RD_LEN;
    kind    = K_RD;
    if (state == S_IDLE) begin
      if (snes_rd_pend) begin
        state_n = S_SNES_RD;
        load    = 1'b1;
      end else if (snes_wr_pend) begin
        state_n = S_SNES_WR;
        load    = 1'b1;
        len     = WR_LEN;
        kind    = K_WR;
      end else if (mcu_pend && guard == '0) begin
        state_n = mcu_wr ? S_MCU_WR : S_MCU_RD;
        load    = 1'b1;
        len     = mcu_wr ? WR_LEN : RD_LEN;
        kind    = mcu_wr ? K_WR : K_RD;
      end
    end else if (last) begin
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snes_rd_pend  <= 1'b0;
      snes_wr_pend  <= 1'b0;
      mcu_pend      <= 1'b0;
      mcu_wr        <= 1'b0;
      srd_addr      <= '0;
      swr           <= '0;
      mreq          <= '0;
      guard         <= GUARD;
      mem_addr      <= '0;
      mem_dout      <= '0;
      snes_data_out <= '0;
      mcu_din       <= '0;
    end else begin
      if (load) begin
        unique case (state_n)
          S_SNES_RD: begin
            snes_rd_pend <= 1'b0;
            mem_addr     <= srd_addr;
          end
          S_SNES_WR: begin
            snes_wr_pend <= 1'b0;
            mem_addr     <= swr.addr;
            mem_dout     <= swr.data;
          end
          default: begin
            mem_addr <= mreq.addr;
            mem_dout <= mreq.data;
          end
        endcase
      end
      if (done) begin
        unique case (state)
          S_SNES_RD: snes_data_out <= bus.mem_din;
          S_MCU_RD: begin
            mcu_din  <= bus.mem_din;
            mcu_pend <= 1'b0;
          end
          S_MCU_WR: mcu_pend <= 1'b0;
          default: ;
        endcase
      end
      if (done && snes_op)
        guard <= GUARD;
      else if (state == S_IDLE && guard != '0)
        guard <= guard - 1'b1;
      // Captures follow the dispatch clears so a same-cycle pulse survives
      if (bus.snes_rd_start && bus.rom_hit) begin
        snes_rd_pend <= 1'b1;
        srd_addr     <= bus.rom_addr;
      end
      if (bus.snes_wr_end && bus.is_writable) begin
        snes_wr_pend <= 1'b1;
        swr <= '{addr: bus.rom_addr, data: bus.snes_data_in};
      end
      if ((bus.mcu_rrq || bus.mcu_wrq) && !mcu_pend) begin
        mcu_pend <= 1'b1;
        mcu_wr   <= bus.mcu_wrq;
        mreq <= '{addr: bus.mcu_addr, data: bus.mcu_dout};
      end
    end
  end

  mem_strobe_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .length (len),
    .kind   (kind),
    .oe_n   (bus.mem_oe_n),
    .we_n   (bus.mem_we_n),
    .drive  (bus.mem_drive),
    .last   (last)
  );

  assign bus.mem_addr      = mem_addr;
  assign bus.mem_dout      = mem_dout;
  assign bus.snes_data_out = snes_data_out;
  assign bus.mcu_din       = mcu_din;
  assign bus.mcu_rdy       = !mcu_pend;

`ifdef ACCESS_STATS_EN
  logic [15:0] stat_rd, stat_defer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd    <= '0;
      stat_defer <= '0;
    end else begin
      if (done && state == S_SNES_RD && stat_rd != 16'hFFFF)
        stat_rd <= stat_rd + 1'b1;
      if (mcu_pend && !mcu_op && stat_defer != 16'hFFFF)
        stat_defer <= stat_defer + 1'b1;
    end
  end

  assign bus.stat_snes_rd   = stat_rd;
  assign bus.stat_mcu_defer = stat_defer;
`else
  assign bus.stat_snes_rd   = '0;
  assign bus.stat_mcu_defer = '0;
`endif

endmodule

// File: doc/snes_mem_sequencer.md
Name: snes_mem_sequencer

Overview:
- Downstream of the address decoder.
- Consumes the decoded ROM_ADDR / ROM_HIT / IS_WRITABLE for each SNES bus cycle and runs the actual cycle on the cartridge SRAM/PSRAM with programmable wait states.
- Fits MCU (host) read/write requests into idle bus time; the SNES always has priority and is never delayed more than one MCU slot.
- Holds the last SNES read byte stable for the data-bus driver.

Parameters:
- RD_CYCLES, 5, CLK cycles MEM_OE_N is held low for any read (SNES or MCU); range 2..15
- WR_CYCLES, 4, CLK cycles MEM_WE_N is held low for any write; range 2..15
- MCU_GUARD, 2, idle CLK cycles required after an SNES op completes before an MCU op may start

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- SNES_RD_START  in  1  one-cycle pulse: SNES read cycle began, address stable
- SNES_WR_END  in  1  one-cycle pulse: SNES write strobe ended, data stable
- ROM_ADDR  in  24  decoded memory address for the current SNES cycle
- ROM_HIT  in  1  current SNES address maps to cartridge memory
- IS_WRITABLE  in  1  current SNES address is writable memory
- SNES_DATA_IN  in  8  SNES write data
- SNES_DATA_OUT  out  8  latched read data for the SNES data bus
- MCU_RRQ  in  1  MCU read request pulse
- MCU_WRQ  in  1  MCU write request pulse
- MCU_ADDR  in  24  MCU address
- MCU_DOUT  in  8  MCU write data
- MCU_DIN  out  8  MCU read data
- MCU_RDY  out  1  high when no MCU request is pending or in flight
- MEM_ADDR  out  24  memory address
- MEM_DOUT  out  8  memory write data
- MEM_DIN  in  8  memory read data
- MEM_OE_N  out  1  memory output enable, active low
- MEM_WE_N  out  1  memory write enable, active low
- MEM_DRIVE  out  1  FPGA drives memory data bus
- STAT_SNES_RD  out  16  SNES read counter (see Optional Feature)
- STAT_MCU_DEFER  out  16  MCU deferral counter (see Optional Feature)

Behaviour:
- Reset values:
  - state IDLE; all pending flags 0
  - MEM_OE_N = MEM_WE_N = 1, MEM_DRIVE = 0, MEM_ADDR = 0, MEM_DOUT = 0
  - SNES_DATA_OUT = 0, MCU_DIN = 0, MCU_RDY = 1, guard counter = MCU_GUARD, STAT_* = 0
- Capture:
  - SNES_RD_START with ROM_HIT=1 sets snes_rd_pend and latches ROM_ADDR.
  - SNES_WR_END with IS_WRITABLE=1 sets snes_wr_pend and latches ROM_ADDR and SNES_DATA_IN.
  - Pulses with ROM_HIT=0 (read) or IS_WRITABLE=0 (write) are ignored entirely.
- MCU capture: MCU_RRQ or MCU_WRQ sets mcu_pend, latches address, data and direction, and drops MCU_RDY the next cycle. A new MCU request arriving while mcu_pend=1 is ignored; the MCU must wait for RDY.
- States: IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR. One wait counter (4 bit) is loaded on entry to each op.
- IDLE priority order: snes_rd_pend, then snes_wr_pend, then mcu_pend. An MCU op starts only if the guard counter is 0.
  - The guard counter reloads to MCU_GUARD when an SNES op ends.
  - It decrements in IDLE and saturates at 0.
- A capture and a dispatch may occur in the same cycle. A pulse arriving in IDLE is dispatched on the following cycle, so MEM_ADDR is valid 1 cycle after START/END.
- SNES_RD:
  - MEM_ADDR = latched address, MEM_OE_N = 0 for RD_CYCLES cycles.
  - In the final cycle, MEM_DIN is registered into SNES_DATA_OUT.
  - Total latency from START to SNES_DATA_OUT valid is RD_CYCLES+1 cycles.
- SNES_WR: MEM_DRIVE = 1 for the whole op, MEM_WE_N = 0 for WR_CYCLES cycles, and MEM_DOUT = latched data.
- MCU_RD / MCU_WR use the same timing. On completion:
  - MCU_DIN is updated (read only)
  - mcu_pend clears
  - MCU_RDY rises the next cycle
- An SNES pulse during an MCU op only sets the pending flag; it is serviced immediately after. Worst-case SNES dispatch delay is max(RD_CYCLES, WR_CYCLES)+1.
- A second SNES_RD_START while a read is still pending overwrites the latched address; the newest read wins and no error is flagged.
- On return to IDLE: OE_N and WE_N go to 1 and MEM_DRIVE goes to 0 on the same edge. Back-to-back ops therefore always have at least one cycle with both strobes high.
- RST asserted mid-operation: strobes deassert immediately (asynchronously), all pending requests are dropped, and MCU_RDY = 1.

Optional Feature:
- Macro ACCESS_STATS_EN.
- Defined:
  - STAT_SNES_RD counts completed SNES reads.
  - STAT_MCU_DEFER counts cycles where mcu_pend=1 but the state is not an MCU op.
  - Both counters are 16-bit, saturate at 0xFFFF, and clear on RST.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Decomposition:
- Shared package (snes_mem_pkg):
  - state encoding enum
  - wait-counter width constant (4)
  - parameter range-check constants (RD/WR min 2, max 15)
- Sub-module mem_strobe_timer:
  - inputs: load, length, kind (rd/wr)
  - outputs: OE_N/WE_N/DRIVE and a last-cycle pulse
  - instantiated once and shared by all ops

Test Plan:
- Reset, then SNES_RD_START with ROM_ADDR=0x123456, ROM_HIT=1, MEM_DIN=0xA5 -> MEM_ADDR=0x123456 at +1, OE_N low for 5 cycles, SNES_DATA_OUT=0xA5 at +6.
- SNES_WR_END with IS_WRITABLE=0 -> no strobe activity. Repeat with IS_WRITABLE=1, data 0x3C, addr 0xE00010 -> WE_N low 4 cycles, MEM_DOUT=0x3C, MEM_DRIVE high for the whole op.
- MCU_RRQ for addr 0x000100 plus SNES_RD_START in the same cycle -> SNES read first; MCU read starts after 2 guard cycles; MCU_RDY returns after the MCU read.
- MCU_WRQ, then SNES_RD_START 1 cycle after MCU_WR starts -> MCU write completes (4 cycles), SNES read dispatched next cycle, never overlapping.
- RST pulsed during SNES_RD cycle 3 -> OE_N=1 asynchronously, all outputs at reset values, no later dispatch.
- ACCESS_STATS_EN: 3 SNES reads -> STAT_SNES_RD=3. Without the macro -> stays 0.
